// File: rtl/onehot_dec_pkg.sv
// Shared types, default sizes and the reference decode function
// for the one-hot-to-binary decoder.
package onehot_dec_pkg;

    // Output buffer occupancy
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } buf_state_t;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_CNT_W = 8;

    // Widest one-hot word the decode function handles; narrower words
    // are zero-extended, which changes neither the lowest set bit nor
    // the popcount.
    localparam int unsigned MAX_N = 256;
    localparam int unsigned MAX_W = 8;

    // Returns {err, idx}: idx is the lowest set bit (0 for an all-zero
    // word), err is set unless exactly one bit is high.
    function automatic logic [MAX_W:0] decode_word(input logic [MAX_N-1:0] word);
        logic [MAX_W-1:0] idx;
        int unsigned      ones;
        idx  = '0;
        ones = 0;
        for (int unsigned i = MAX_N; i > 0; i--) begin
            if (word[i-1]) begin
                idx = MAX_W'(i - 1);
            end
        end
        for (int unsigned i = 0; i < MAX_N; i++) begin
            ones = ones + {31'b0, word[i]};
        end
        return {(ones != 1), idx};
    endfunction

endpackage

// File: rtl/onehot_to_bin_decoder_if.sv
// Handshake bundle between a producer of one-hot words, the decoder
// and the downstream consumer of binary indices.
interface onehot_to_bin_decoder_if
    import onehot_dec_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    localparam int unsigned W = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_code;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_idx;
    logic             out_err;
    logic             clr_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_code, out_ready, clr_count,
        input  in_ready, out_valid, out_idx, out_err, err_count
    );

    modport slave (
        input  in_valid, in_code, out_ready, clr_count,
        output in_ready, out_valid, out_idx, out_err, err_count
    );

endinterface

// File: rtl/onehot_dec_core.sv
// Combinational lowest-set-bit index and exactly-one-hot check.
module onehot_dec_core
    import onehot_dec_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0]         code,
    output logic [$clog2(N)-1:0] idx,
    output logic                 err
);
    localparam int unsigned W = $clog2(N);

    logic [MAX_N-1:0] wide;
    logic [MAX_W:0]   res;

    // Zero-extend to the function's width and split its {err, idx} result
    always_comb begin
        wide         = '0;
        wide[N-1:0]  = code;
        res          = decode_word(wide);
        idx          = W'(res[MAX_W-1:0]);
        err          = res[MAX_W];
    end

endmodule

// File: rtl/onehot_to_bin_decoder.sv
// Registered, flow-controlled one-hot-to-binary decoder with a two-entry
// output buffer and a saturating count of accepted erroneous words.
module onehot_to_bin_decoder
    import onehot_dec_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst,
    onehot_to_bin_decoder_if.slave bus
);
    localparam int unsigned W = $clog2(N);

    logic [W-1:0]     dec_idx;
    logic             dec_err;
    buf_state_t       state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [W-1:0]     head_idx;
    logic             head_err;
    logic [W-1:0]     tail_idx;
    logic             tail_err;
    logic [CNT_W-1:0] err_count_q;
    logic             accept;
    logic             pop;

    onehot_dec_core #(.N(N)) u_core (
        .code (bus.in_code),
        .idx  (dec_idx),
        .err  (dec_err)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = head_idx;
    assign bus.out_err   = head_err;
    assign bus.err_count = err_count_q;

    // Occupancy FSM; head is the presented word, tail the one waiting
    // behind it. in_ready/out_valid are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_idx    <= '0;
            head_err    <= 1'b0;
            tail_idx    <= '0;
            tail_err    <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        head_idx    <= dec_idx;
                        head_err    <= dec_err;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        tail_idx   <= dec_idx;
                        tail_err   <= dec_err;
                        in_ready_q <= 1'b0;
                        state      <= TWO;
                    end else if (pop && !accept) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end else if (pop && accept) begin
                        head_idx <= dec_idx;
                        head_err <= dec_err;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_idx   <= tail_idx;
                        head_err   <= tail_err;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    // Saturating error counter, updated at accept time; an erroneous
    // accept in a clear cycle leaves the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (bus.clr_count) begin
            err_count_q <= (accept && dec_err) ? CNT_W'(1) : '0;
        end else if (accept && dec_err && (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

endmodule
